// File: rtl/uart_pkg.sv
// Shared UART types and helpers: transmitter state encoding, line levels, baud divisor.
// Latency: n/a (package). Backpressure: n/a.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_BIT = 1'b0;

  function automatic int baud_div(input int clk_freq, input int rate);
    return clk_freq / rate;
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Generic synchronous FIFO with wrap-bit pointers; head word is visible on dout while not empty.
// Latency: one cycle from push to non-empty. Backpressure: push ignored when full, pop ignored when empty.
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           din,
  input  logic                       pop,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign level   = wr_ptr - rd_ptr;
  assign full    = (level == (AW+1)'(DEPTH));
  assign empty   = (wr_ptr == rd_ptr);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr[AW-1:0]];

  // Storage carries no reset: clearing the pointers is enough to discard queued data.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr[AW-1:0]] <= din;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

endmodule

// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter behind an input FIFO; parity stage built only with UART_TX_PARITY_EN.
// Latency: tx falls one cycle after a character is accepted into an idle, empty path. Backpressure: tx_ready low while the FIFO is full.
module uart_tx_cfg
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BODE_RATE  = 115_200,
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter int PARITY_ODD = 0,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          tx_data_valid,
  input  logic [DATA_BITS-1:0]          tx_data,
  output logic                          tx_ready,
  output logic                          tx,
  output logic                          tx_busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int DIV = baud_div(CLK_FREQ, BODE_RATE);
  localparam int CW  = (DIV < 2) ? 1 : $clog2(DIV);

  if (DIV < 2) begin : g_div_chk
    $error("uart_tx_cfg: clocks per bit must be at least 2");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bits_chk
    $error("uart_tx_cfg: DATA_BITS must be 5..9");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_stop_chk
    $error("uart_tx_cfg: STOP_BITS must be 1 or 2");
  end
  if (PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_par_chk
    $error("uart_tx_cfg: PARITY_ODD must be 0 or 1");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_depth_chk
    $error("uart_tx_cfg: FIFO_DEPTH must be a power of two, at least 2");
  end

  tx_state_t             state_q, state_nxt;
  logic [CW-1:0]         baud_q, baud_nxt;
  logic [3:0]            bit_q, bit_nxt;
  logic [DATA_BITS-1:0]  shift_q, shift_nxt;
  logic                  tx_q, tx_nxt;
  logic                  pop;
  logic                  baud_end;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [DATA_BITS-1:0]  fifo_dout;

  uart_sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (tx_data_valid),
    .din   (tx_data),
    .pop   (pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  assign tx_ready = !fifo_full;
  assign tx_busy  = (state_q != IDLE) || !fifo_empty;
  assign tx       = tx_q;
  assign baud_end = (baud_q == CW'(DIV - 1));

`ifdef UART_TX_PARITY_EN
  logic par_q, par_nxt;
`endif

  always_comb begin
    state_nxt = state_q;
    baud_nxt  = baud_q;
    bit_nxt   = bit_q;
    shift_nxt = shift_q;
    pop       = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_nxt   = par_q;
`endif
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop       = 1'b1;
          shift_nxt = fifo_dout;
          state_nxt = START;
          baud_nxt  = '0;
          bit_nxt   = '0;
        end
      end
      START: begin
        baud_nxt = baud_q + CW'(1);
        if (baud_end) begin
          baud_nxt  = '0;
          state_nxt = DATA;
        end
      end
      DATA: begin
        baud_nxt = baud_q + CW'(1);
        if (baud_end) begin
          baud_nxt  = '0;
          shift_nxt = shift_q >> 1;
          if (bit_q == 4'(DATA_BITS - 1)) begin
            bit_nxt = '0;
`ifdef UART_TX_PARITY_EN
            state_nxt = PARITY;
`else
            state_nxt = STOP;
`endif
          end else begin
            bit_nxt = bit_q + 4'd1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        baud_nxt = baud_q + CW'(1);
        if (baud_end) begin
          baud_nxt  = '0;
          state_nxt = STOP;
        end
      end
`endif
      STOP: begin
        baud_nxt = baud_q + CW'(1);
        if (baud_end) begin
          baud_nxt = '0;
          if (bit_q == 4'(STOP_BITS - 1)) begin
            bit_nxt = '0;
            // Chain straight into the next start bit so frames go out back-to-back.
            if (!fifo_empty) begin
              pop       = 1'b1;
              shift_nxt = fifo_dout;
              state_nxt = START;
            end else begin
              state_nxt = IDLE;
            end
          end else begin
            bit_nxt = bit_q + 4'd1;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        baud_nxt  = '0;
        bit_nxt   = '0;
      end
    endcase

`ifdef UART_TX_PARITY_EN
    if (pop) par_nxt = (^fifo_dout) ^ PARITY_ODD[0];
`endif

    // Line level is decoded from the next state so the registered tx lines up with state_q.
    tx_nxt = LINE_IDLE;
    case (state_nxt)
      START:   tx_nxt = START_BIT;
      DATA:    tx_nxt = shift_nxt[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  tx_nxt = par_nxt;
`endif
      default: tx_nxt = LINE_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= LINE_IDLE;
    end else begin
      state_q <= state_nxt;
      baud_q  <= baud_nxt;
      bit_q   <= bit_nxt;
      shift_q <= shift_nxt;
      tx_q    <= tx_nxt;
    end
  end

`ifdef UART_TX_PARITY_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) par_q <= 1'b0;
    else      par_q <= par_nxt;
  end
`endif

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Directed + randomized bench for uart_tx_cfg: two instances (8N1 and 7-bit/2-stop) checked against a frame model.
module tb_uart_tx_cfg;

  localparam int DIV    = 10;
  localparam int A_BITS = 8;
  localparam int A_STOP = 1;
  localparam int A_ODD  = 0;
  localparam int B_BITS = 7;
  localparam int B_STOP = 2;
  localparam int B_ODD  = 1;
`ifdef UART_TX_PARITY_EN
  localparam int PEN = 1;
`else
  localparam int PEN = 0;
`endif

  logic       clk;
  logic       rst;
  logic       a_vld, b_vld;
  logic [7:0] a_dat;
  logic [6:0] b_dat;
  logic       a_rdy, b_rdy, a_tx, b_tx, a_busy, b_busy;
  logic [2:0] a_lvl, b_lvl;

  int errors = 0;
  int checks = 0;
  int vals [0:15];
  logic full_seen;

  uart_tx_cfg #(
    .CLK_FREQ(100_000_000), .BODE_RATE(10_000_000), .DATA_BITS(A_BITS),
    .STOP_BITS(A_STOP), .PARITY_ODD(A_ODD), .FIFO_DEPTH(4)
  ) dut_a (
    .clk(clk), .rst(rst), .tx_data_valid(a_vld), .tx_data(a_dat),
    .tx_ready(a_rdy), .tx(a_tx), .tx_busy(a_busy), .fifo_level(a_lvl)
  );

  uart_tx_cfg #(
    .CLK_FREQ(100_000_000), .BODE_RATE(10_000_000), .DATA_BITS(B_BITS),
    .STOP_BITS(B_STOP), .PARITY_ODD(B_ODD), .FIFO_DEPTH(4)
  ) dut_b (
    .clk(clk), .rst(rst), .tx_data_valid(b_vld), .tx_data(b_dat),
    .tx_ready(b_rdy), .tx(b_tx), .tx_busy(b_busy), .fifo_level(b_lvl)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Expected line level of bit slot idx in a frame carrying data.
  function automatic logic exp_bit(input int idx, input int data, input int nbits, input int odd);
    int d;
    d = data & ((1 << nbits) - 1);
    if (idx == 0) return 1'b0;
    if (idx <= nbits) return 1'((d >> (idx - 1)) & 1);
    if (PEN == 1 && idx == nbits + 1) return 1'(($countones(d) + odd) % 2);
    return 1'b1;
  endfunction

  task automatic check1(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic get_tx(input bit sel);
    return sel ? b_tx : a_tx;
  endfunction

  // Called just after the edge where the start bit should begin; returns on the edge after the frame.
  task automatic check_frame(input bit sel, input int data);
    int nb, ns, odd, len;
    logic e, o, s;
    nb  = sel ? B_BITS : A_BITS;
    ns  = sel ? B_STOP : A_STOP;
    odd = sel ? B_ODD : A_ODD;
    len = 1 + nb + PEN + ns;
    for (int b = 0; b < len; b++) begin
      e = exp_bit(b, data, nb, odd);
      o = 1'bx;
      for (int c = 0; c < DIV; c++) begin
        @(negedge clk);
        s = get_tx(sel);
        if (c == 0 || s !== e) o = s;
        @(posedge clk);
      end
      checks++;
      assert (o === e) else begin
        errors++;
        $error("FAIL frame sel=%0d data=%0h bit=%0d observed=%b expected=%b", sel, data, b, o, e);
      end
    end
  endtask

  task automatic wait_start(input bit sel);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(posedge clk);
      #1;
      if (get_tx(sel) === 1'b0) begin
        found = 1'b1;
        break;
      end
    end
    check1("start_timeout", 32'(found), 32'd1);
  endtask

  task automatic push_seq(input bit sel, input int n);
    int idx, guard;
    logic acc;
    idx = 0;
    guard = 0;
    if (sel) begin b_vld = 1'b1; b_dat = 7'(vals[0]); end
    else     begin a_vld = 1'b1; a_dat = 8'(vals[0]); end
    while (idx < n && guard < 5000) begin
      @(negedge clk);
      acc = sel ? b_rdy : a_rdy;
      if (!sel && a_lvl == 3'd4 && a_rdy == 1'b0) full_seen = 1'b1;
      if (sel && b_lvl == 3'd4 && b_rdy == 1'b0) full_seen = 1'b1;
      @(posedge clk);
      guard++;
      if (acc) idx++;
      #1;
      if (sel) begin
        if (idx < n) b_dat = 7'(vals[idx]); else b_vld = 1'b0;
      end else begin
        if (idx < n) a_dat = 8'(vals[idx]); else a_vld = 1'b0;
      end
    end
    check1("push_timeout", 32'(idx), 32'(n));
  endtask

  task automatic check_seq(input bit sel, input int n);
    wait_start(sel);
    for (int j = 0; j < n; j++) check_frame(sel, vals[j]);
    #1;
    check1(sel ? "b_busy_end" : "a_busy_end", 32'(sel ? b_busy : a_busy), 32'd0);
    check1(sel ? "b_tx_end" : "a_tx_end", 32'(get_tx(sel)), 32'd1);
    check1(sel ? "b_lvl_end" : "a_lvl_end", 32'(sel ? b_lvl : a_lvl), 32'd0);
  endtask

  initial begin
    logic saw;
    rst   = 1'b0;
    a_vld = 1'b0;
    b_vld = 1'b0;
    a_dat = '0;
    b_dat = '0;
    full_seen = 1'b0;

    // Reset values while held, and after release.
    repeat (3) @(posedge clk);
    #1;
    check1("rst_tx", 32'(a_tx), 32'd1);
    check1("rst_rdy", 32'(a_rdy), 32'd1);
    check1("rst_busy", 32'(a_busy), 32'd0);
    check1("rst_lvl", 32'(a_lvl), 32'd0);
    check1("rst_b_tx", 32'(b_tx), 32'd1);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check1("rel_tx", 32'(a_tx), 32'd1);
    check1("rel_rdy", 32'(a_rdy), 32'd1);
    check1("rel_busy", 32'(a_busy), 32'd0);
    check1("rel_lvl", 32'(a_lvl), 32'd0);

    // Single 0xA5 with exact first-bit latency.
    @(negedge clk);
    a_vld = 1'b1;
    a_dat = 8'hA5;
    @(posedge clk);
    #1;
    a_vld = 1'b0;
    check1("acc_tx_still_idle", 32'(a_tx), 32'd1);
    check1("acc_lvl", 32'(a_lvl), 32'd1);
    check1("acc_busy", 32'(a_busy), 32'd1);
    @(posedge clk);
    #1;
    check1("pop_tx_low", 32'(a_tx), 32'd0);
    check1("pop_lvl", 32'(a_lvl), 32'd0);
    check_frame(1'b0, 8'hA5);
    #1;
    check1("single_busy_end", 32'(a_busy), 32'd0);
    check1("single_tx_end", 32'(a_tx), 32'd1);

    // Burst of six with valid held: FIFO fills, frames go out with no gap.
    for (int i = 0; i < 6; i++) vals[i] = i + 1;
    full_seen = 1'b0;
    fork
      push_seq(1'b0, 6);
      check_seq(1'b0, 6);
    join
    check1("burst_full_seen", 32'(full_seen), 32'd1);

    // 0xDD exercises parity when the stage is built.
    vals[0] = 8'hDD;
    fork
      push_seq(1'b0, 1);
      check_seq(1'b0, 1);
    join

    // 7 data bits, 2 stop bits.
    vals[0] = 7'h55;
    fork
      push_seq(1'b1, 1);
      check_seq(1'b1, 1);
    join

    // Random characters on both instances.
    for (int i = 0; i < 5; i++) vals[i] = int'($urandom_range(0, 255));
    fork
      push_seq(1'b0, 5);
      check_seq(1'b0, 5);
    join
    for (int i = 0; i < 4; i++) vals[i] = int'($urandom_range(0, 127));
    fork
      push_seq(1'b1, 4);
      check_seq(1'b1, 4);
    join

    // Reset during data bit 3 with two characters queued.
    for (int i = 0; i < 3; i++) vals[i] = int'($urandom_range(0, 255));
    fork
      push_seq(1'b0, 3);
      begin
        wait_start(1'b0);
        repeat (45) @(posedge clk);
        #1;
        check1("pre_rst_lvl", 32'(a_lvl), 32'd2);
        rst = 1'b0;
        #1;
        check1("mid_rst_tx", 32'(a_tx), 32'd1);
        check1("mid_rst_lvl", 32'(a_lvl), 32'd0);
        check1("mid_rst_rdy", 32'(a_rdy), 32'd1);
        check1("mid_rst_busy", 32'(a_busy), 32'd0);
      end
    join
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    saw = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (a_tx !== 1'b1 || a_busy !== 1'b0) saw = 1'b1;
    end
    check1("post_rst_quiet", 32'(saw), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
